nibble_serial_adder: RTL and testbench

Multi-cycle wide adder that sequences W-bit operands, one 4-bit nibble per clock, LSB first, through the team's 4-bit ripple-carry adder (`rca`). It sits directly upstream of `rca`, driving its operand and carry-in pins, and consumes its sum and carry outputs. Per-nibble carry is registered between cycles, and the assembled result is presented with a done pulse. It is used where a full-width adder is too large and throughput of one add per NIBBLES+1 cycles is sufficient.

---
 rtl/nibble_serial_adder_pkg.sv | 16 +
 rtl/nibble_serial_adder_if.sv | 28 ++
 rtl/nibble_serial_adder_rca.sv | 22 ++
 rtl/nibble_serial_adder.sv | 111 +++++++++++
 tb/tb_nibble_serial_adder.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants and FSM encoding for the nibble-serial adder.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Request/result bundle between a requester and the nibble-serial adder.
interface nibble_serial_adder_if #(
  parameter int NIBBLES = 4
);
  import nibble_serial_adder_pkg::*;

  localparam int W = NIBBLE_W * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/nibble_serial_adder_rca.sv
// 4-bit ripple-carry adder slice.
module rca (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);

  always_comb begin
    logic cy;
    cy  = c_i;
    s_o = '0;
    for (int i = 0; i < 4; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ cy;
      cy     = (a_i[i] & b_i[i]) |
               (cy & (a_i[i] ^ b_i[i]));
    end
    c_o = cy;
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that feeds one nibble per clock through a 4-bit rca,
// LSB first, registering the carry between slices.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  nibble_serial_adder_if.slave bus
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = idx_w(NIBBLES);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    res_q, res_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;

  logic [NIBBLE_W-1:0] rca_s;
  logic                rca_c;
  logic [W-1:0]        res_next;
  logic                last;
  logic                accept;

  rca u_rca (
    .a_i (a_q[NIBBLE_W-1:0]),
    .b_i (b_q[NIBBLE_W-1:0]),
    .c_i (carry_q),
    .s_o (rca_s),
    .c_o (rca_c)
  );

  // New sum nibble enters at the top; after NIBBLES shifts it is aligned.
  assign res_next = W'({rca_s, res_q} >> NIBBLE_W);
  assign last     = (idx_q == IW'(NIBBLES - 1));
  assign accept   = bus.start && (state_q != RUN);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = RUN;
      end
      RUN: begin
        res_d   = res_next;
        carry_d = rca_c;
        a_d     = a_q >> NIBBLE_W;
        b_d     = b_q >> NIBBLE_W;
        idx_d   = idx_q + IW'(1);
        if (last) begin
          state_d = DONE;
          sum_d   = res_next;
          cout_d  = rca_c;
        end
      end
      DONE: begin
        state_d = bus.start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      a_d     = bus.a;
      b_d     = bus.b;
      carry_d = bus.cin;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for the nibble-serial adder, NIBBLES = 4 and 1.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nibble_serial_adder_if #(.NIBBLES(4)) bus4 ();
  nibble_serial_adder_if #(.NIBBLES(1)) bus1 ();

  nibble_serial_adder #(.NIBBLES(4)) u4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  nibble_serial_adder #(.NIBBLES(1)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  int errors = 0;
  int checks = 0;
  logic [16:0] q4[$];
  logic [4:0]  q1[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start4(input logic [15:0] a, input logic [15:0] b,
                        input logic c);
    bus4.a     = a;
    bus4.b     = b;
    bus4.cin   = c;
    bus4.start = 1'b1;
    q4.push_back({1'b0, a} + {1'b0, b} + 17'(c));
  endtask

  task automatic start1(input logic [3:0] a, input logic [3:0] b,
                        input logic c);
    bus1.a     = a;
    bus1.b     = b;
    bus1.cin   = c;
    bus1.start = 1'b1;
    q1.push_back({1'b0, a} + {1'b0, b} + 5'(c));
  endtask

  task automatic test_reset;
    bus4.start = 0; bus4.a = '0; bus4.b = '0; bus4.cin = 0;
    bus1.start = 0; bus1.a = '0; bus1.b = '0; bus1.cin = 0;
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if (bus4.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", bus4.busy);
    end
    checks++;
    if (bus4.done !== 1'b0) begin
      errors++; $display("FAIL reset_done: got %b want 0", bus4.done);
    end
    checks++;
    if ({bus4.cout, bus4.sum} !== 17'h0) begin
      errors++;
      $display("FAIL reset_sum: got %h want 0", {bus4.cout, bus4.sum});
    end
    checks++;
    if ({bus1.busy, bus1.done, bus1.cout, bus1.sum} !== 7'h0) begin
      errors++;
      $display("FAIL reset_n1: got %h want 0",
               {bus1.busy, bus1.done, bus1.cout, bus1.sum});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ripple;
    logic [16:0] exp;
    start4(16'hFFFF, 16'h0001, 1'b0);
    tick();
    bus4.start = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus4.busy, bus4.done} !== 2'b10) begin
        errors++;
        $display("FAIL ripple_busy%0d: got busy/done %b%b want 10",
                 i, bus4.busy, bus4.done);
      end
      tick();
    end
    checks++;
    if ({bus4.busy, bus4.done} !== 2'b01) begin
      errors++;
      $display("FAIL ripple_done: got busy/done %b%b want 01",
               bus4.busy, bus4.done);
    end
    exp = q4.pop_front();
    checks++;
    if ({bus4.cout, bus4.sum} !== exp) begin
      errors++;
      $display("FAIL ripple_sum: got %h want %h", {bus4.cout, bus4.sum}, exp);
    end
    tick();
    checks++;
    if ({bus4.done, bus4.cout, bus4.sum} !== {1'b0, exp}) begin
      errors++;
      $display("FAIL ripple_idle: got done=%b res=%h want done=0 res=%h",
               bus4.done, {bus4.cout, bus4.sum}, exp);
    end
  endtask

  task automatic test_hold_sum;
    logic [16:0] exp;
    start4(16'h1234, 16'h4321, 1'b1);
    tick();
    bus4.start = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus4.cout, bus4.sum} !== 17'h10000) begin
        errors++;
        $display("FAIL hold_sum%0d: got %h want 10000",
                 i, {bus4.cout, bus4.sum});
      end
      tick();
    end
    exp = q4.pop_front();
    checks++;
    if ({bus4.done, bus4.cout, bus4.sum} !== {1'b1, exp}) begin
      errors++;
      $display("FAIL hold_result: got done=%b res=%h want done=1 res=%h",
               bus4.done, {bus4.cout, bus4.sum}, exp);
    end
    tick();
  endtask

  task automatic test_ignore_start;
    logic [16:0] exp;
    int pulses;
    int at;
    pulses = 0;
    at = -1;
    start4(16'h1111, 16'h2222, 1'b0);
    tick();
    bus4.start = 0;
    tick();
    bus4.start = 1;
    bus4.a     = 16'hAAAA;
    tick();
    bus4.start = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus4.done === 1'b1) begin
        pulses++;
        at = i;
        if (q4.size() > 0) begin
          exp = q4.pop_front();
          checks++;
          if ({bus4.cout, bus4.sum} !== exp) begin
            errors++;
            $display("FAIL ignore_sum: got %h want %h",
                     {bus4.cout, bus4.sum}, exp);
          end
        end
      end
      tick();
    end
    checks++;
    if (pulses != 1 || at != 2) begin
      errors++;
      $display("FAIL ignore_pulses: got %0d at %0d want 1 at 2", pulses, at);
    end
  endtask

  task automatic test_reset_mid;
    logic [16:0] exp;
    int pulses;
    pulses = 0;
    start4(16'h5555, 16'h1234, 1'b0);
    tick();
    bus4.start = 0;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({bus4.busy, bus4.done, bus4.cout, bus4.sum} !== 19'h0) begin
      errors++;
      $display("FAIL rstmid_outs: got %h want 0",
               {bus4.busy, bus4.done, bus4.cout, bus4.sum});
    end
    void'(q4.pop_back());
    #2;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus4.done === 1'b1 || bus4.busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL rstmid_nodone: got %0d active cycles want 0", pulses);
    end
    start4(16'h00FF, 16'h0001, 1'b0);
    tick();
    bus4.start = 0;
    repeat (4) tick();
    exp = q4.pop_front();
    checks++;
    if ({bus4.done, bus4.cout, bus4.sum} !== {1'b1, exp}) begin
      errors++;
      $display("FAIL rstmid_after: got done=%b res=%h want done=1 res=%h",
               bus4.done, {bus4.cout, bus4.sum}, exp);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [16:0] exp;
    start4(16'h0F0F, 16'h1010, 1'b1);
    tick();
    bus4.start = 0;
    repeat (4) tick();
    exp = q4.pop_front();
    checks++;
    if ({bus4.done, bus4.cout, bus4.sum} !== {1'b1, exp}) begin
      errors++;
      $display("FAIL b2b_first: got done=%b res=%h want done=1 res=%h",
               bus4.done, {bus4.cout, bus4.sum}, exp);
    end
    start4(16'h8000, 16'h8000, 1'b0);
    tick();
    bus4.start = 0;
    checks++;
    if ({bus4.busy, bus4.done} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_restart: got busy/done %b%b want 10",
               bus4.busy, bus4.done);
    end
    repeat (4) tick();
    exp = q4.pop_front();
    checks++;
    if ({bus4.done, bus4.cout, bus4.sum} !== {1'b1, exp}) begin
      errors++;
      $display("FAIL b2b_second: got done=%b res=%h want done=1 res=%h",
               bus4.done, {bus4.cout, bus4.sum}, exp);
    end
    tick();
  endtask

  task automatic test_n1;
    logic [4:0] exp;
    start1(4'hF, 4'hF, 1'b1);
    tick();
    bus1.start = 0;
    checks++;
    if ({bus1.busy, bus1.done} !== 2'b10) begin
      errors++;
      $display("FAIL n1_busy: got busy/done %b%b want 10",
               bus1.busy, bus1.done);
    end
    tick();
    exp = q1.pop_front();
    checks++;
    if ({bus1.busy, bus1.done, bus1.cout, bus1.sum} !== {2'b01, exp}) begin
      errors++;
      $display("FAIL n1_done: got %b/%b res=%h want 0/1 res=%h",
               bus1.busy, bus1.done, {bus1.cout, bus1.sum}, exp);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_ripple();
    test_hold_sum();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_n1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
